// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM feeding a small
// instruction buffer toward decode, with branch redirect and response discard.
module fetch_stage #(
  parameter int unsigned              WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0]    BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned              FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  output logic                  instr_valid_o,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic [WORD_WIDTH-1:0] pc_o,
  input  logic                  decode_ready_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_GNT    = 2'd1;
  localparam logic [1:0] WAIT_RVALID = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  discard_q, discard_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [WORD_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];

  logic [WORD_WIDTH-1:0] branch_pc;
  logic                  fifo_empty, fifo_full;
  logic                  resp, push, pop, credit;

  assign branch_pc  = {branch_target_i[WORD_WIDTH-1:2], 2'b00};
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == Depth);
  assign resp       = (state_q == WAIT_RVALID) && instr_rvalid_i;
  // A redirect in the response cycle drops that response along with the flush.
  assign push       = resp && !discard_q && !branch_i;
  assign pop        = !fifo_empty && decode_ready_i && !branch_i;
  assign credit     = (count_d < Depth);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (!push && pop) count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    if (branch_i) fetch_pc_d = branch_pc;
    case (state_q)
      IDLE: begin
        if (credit) begin
          state_d    = WAIT_GNT;
          req_addr_d = fetch_pc_d;
        end
      end
      WAIT_GNT: begin
        if (branch_i) discard_d = 1'b1;
        if (instr_gnt_i) begin
          state_d = WAIT_RVALID;
          // After a redirect fetch_pc already holds the target; do not step it.
          if (!branch_i && !discard_q) fetch_pc_d = fetch_pc_q + WORD_WIDTH'(4);
        end
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          discard_d = 1'b0;
          if (credit) begin
            state_d    = WAIT_GNT;
            req_addr_d = fetch_pc_d;
          end else begin
            state_d = IDLE;
          end
        end else if (branch_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= BOOT_ADDR;
      req_addr_q <= BOOT_ADDR;
      discard_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= instr_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= req_addr_q;
    end
  end

  assign instr_req_o   = (state_q == WAIT_GNT);
  assign instr_addr_o  = req_addr_q;
  assign instr_valid_o = !fifo_empty;
  assign instruction_o = fifo_empty ? '0 : fifo_instr_q[rd_ptr_q];
  assign pc_o          = fifo_empty ? BOOT_ADDR : fifo_pc_q[rd_ptr_q];

  push_when_full_a : assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, backpressure, grant stall with redirect,
// redirect on response, address wrap and mid-transaction reset.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        decode_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] pop_pc [$];
  logic [31:0] pop_ins [$];

  fetch_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .instr_valid_o  (instr_valid_o),
    .instruction_o  (instruction_o),
    .pc_o           (pc_o),
    .decode_ready_i (decode_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i = '0;
    branch_i = 1'b0;
    branch_target_i = '0;
    decode_ready_i = 1'b0;
    pend = 1'b0;
    pend_addr = '0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Memory with immediate grant and one-cycle response; records pops.
  task automatic run_mem(input int n);
    logic        nxt;
    logic [31:0] nxt_addr;
    for (int i = 0; i < n; i++) begin
      instr_gnt_i    = instr_req_o;
      instr_rvalid_i = pend;
      instr_rdata_i  = pend ? data_of(pend_addr) : '0;
      if (instr_valid_o && decode_ready_i) begin
        pop_pc.push_back(pc_o);
        pop_ins.push_back(instruction_o);
      end
      nxt      = instr_req_o;
      nxt_addr = instr_addr_o;
      step();
      pend      = nxt;
      pend_addr = nxt_addr;
    end
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    checks++;
    if (instr_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b exp 0", instr_req_o);
    end
    checks++;
    if (instr_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h exp 00000000", instr_addr_o);
    end
    checks++;
    if (instr_valid_o !== 1'b0 || instruction_o !== 32'h0 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_head: got v=%b i=%h pc=%h exp v=0 i=0 pc=0",
               instr_valid_o, instruction_o, pc_o);
    end
    do_reset();
    step();
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=0", instr_req_o, instr_addr_o);
    end
  endtask

  task automatic test_boot();
    do_reset();
    decode_ready_i = 1'b0;
    step();
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    checks++;
    if (instr_req_o !== 1'b0) begin
      errors++; $display("FAIL boot_req_low: got %b exp 0", instr_req_o);
    end
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h0000_0013;
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instruction_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL boot_head: got v=%b pc=%h i=%h exp v=1 pc=0 i=00000013",
               instr_valid_o, pc_o, instruction_o);
    end
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h4) begin
      errors++;
      $display("FAIL boot_second_req: got req=%b addr=%h exp req=1 addr=4", instr_req_o, instr_addr_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    decode_ready_i = 1'b0;
    run_mem(12);
    checks++;
    if (instr_req_o !== 1'b0) begin
      errors++; $display("FAIL bp_req_low: got %b exp 0", instr_req_o);
    end
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instruction_o !== data_of(32'h0)) begin
      errors++;
      $display("FAIL bp_head: got v=%b pc=%h i=%h exp v=1 pc=0 i=%h",
               instr_valid_o, pc_o, instruction_o, data_of(32'h0));
    end
    // Stray response with nothing outstanding must be ignored.
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hDEAD_BEEF;
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_stray_rvalid: got v=%b pc=%h req=%b exp v=1 pc=0 req=0",
               instr_valid_o, pc_o, instr_req_o);
    end
    pop_pc.delete();
    pop_ins.delete();
    decode_ready_i = 1'b1;
    run_mem(20);
    checks++;
    if (pop_pc.size() < 6) begin
      errors++; $display("FAIL bp_pop_count: got %0d exp >=6", pop_pc.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < pop_pc.size()) begin
        checks++;
        if (pop_pc[i] !== 32'(4 * i) || pop_ins[i] !== data_of(32'(4 * i))) begin
          errors++;
          $display("FAIL bp_order[%0d]: got pc=%h i=%h exp pc=%h i=%h", i, pop_pc[i], pop_ins[i],
                   32'(4 * i), data_of(32'(4 * i)));
        end
      end
    end
    decode_ready_i = 1'b0;
  endtask

  task automatic test_grant_stall();
    do_reset();
    decode_ready_i = 1'b1;
    step();
    step();
    branch_i = 1'b1;
    branch_target_i = 32'h100;
    step();
    branch_i = 1'b0;
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL stall_hold: got req=%b addr=%h exp req=1 addr=0", instr_req_o, instr_addr_o);
    end
    step();
    step();
    step();
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold_late: got req=%b addr=%h v=%b exp req=1 addr=0 v=0",
               instr_req_o, instr_addr_o, instr_valid_o);
    end
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hBAD0_0000;
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_drop: got v=%b pc=%h exp v=0", instr_valid_o, pc_o);
    end
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL stall_target_req: got req=%b addr=%h exp req=1 addr=100",
               instr_req_o, instr_addr_o);
    end
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data_of(32'h100);
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instruction_o !== data_of(32'h100)) begin
      errors++;
      $display("FAIL stall_target_head: got v=%b pc=%h i=%h exp v=1 pc=100 i=%h",
               instr_valid_o, pc_o, instruction_o, data_of(32'h100));
    end
    decode_ready_i = 1'b0;
  endtask

  task automatic test_branch_rvalid_pop();
    do_reset();
    decode_ready_i = 1'b0;
    step();
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data_of(32'h0);
    step();
    instr_rvalid_i = 1'b0;
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i  = 1'b1;
    instr_rdata_i   = data_of(32'h4);
    decode_ready_i  = 1'b1;
    branch_i        = 1'b1;
    branch_target_i = 32'h203;
    step();
    instr_rvalid_i = 1'b0;
    decode_ready_i = 1'b0;
    branch_i       = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL br_flush: got v=%b pc=%h exp v=0", instr_valid_o, pc_o);
    end
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL br_req: got req=%b addr=%h exp req=1 addr=200", instr_req_o, instr_addr_o);
    end
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data_of(32'h200);
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h200 || instruction_o !== data_of(32'h200)) begin
      errors++;
      $display("FAIL br_head: got v=%b pc=%h i=%h exp v=1 pc=200 i=%h",
               instr_valid_o, pc_o, instruction_o, data_of(32'h200));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    decode_ready_i  = 1'b0;
    branch_i        = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    step();
    branch_i = 1'b0;
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req_top: got req=%b addr=%h exp req=1 addr=fffffffc",
               instr_req_o, instr_addr_o);
    end
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data_of(32'hFFFF_FFFC);
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_req_zero: got req=%b addr=%h exp req=1 addr=0", instr_req_o, instr_addr_o);
    end
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_head: got v=%b pc=%h exp v=1 pc=fffffffc", instr_valid_o, pc_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    decode_ready_i = 1'b0;
    step();
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data_of(32'h0);
    step();
    instr_rvalid_i = 1'b0;
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++;
    if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_req: got req=%b addr=%h exp req=0 addr=0", instr_req_o, instr_addr_o);
    end
    checks++;
    if (instr_valid_o !== 1'b0 || instruction_o !== 32'h0 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_head: got v=%b i=%h pc=%h exp v=0 i=0 pc=0",
               instr_valid_o, instruction_o, pc_o);
    end
    step();
    rst_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data_of(32'h4);
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_late_rvalid: got v=%b req=%b addr=%h exp v=0 req=1 addr=0",
               instr_valid_o, instr_req_o, instr_addr_o);
    end
    instr_gnt_i = 1'b1;
    step();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data_of(32'h0);
    step();
    instr_rvalid_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instruction_o !== data_of(32'h0)) begin
      errors++;
      $display("FAIL rstmid_refetch: got v=%b pc=%h i=%h exp v=1 pc=0 i=%h",
               instr_valid_o, pc_o, instruction_o, data_of(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_grant_stall();
    test_branch_rvalid_pop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
